// File: rtl/area_reciprocal.sv
// area_reciprocal: computes floor(2^40 / area) for a triangle area, one quotient bit per cycle.
// Latency: result strobe 42 cycles after acceptance; zero-area or culled inputs report after 1 cycle.
// Backpressure: ready_out is low while dividing; a new input may be accepted in the result cycle.
// Optional feature macro: AREA_RECIPROCAL_CULL_EN (culls negative-winding, non-zero-area inputs).
module area_reciprocal (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic        negative_in,
  input  logic [33:0] area_in,
  output logic        ready_out,
  output logic        valid_out,
  output logic [40:0] recip_out,
  output logic        negative_out,
  output logic        degenerate_out,
  output logic        culled_out
);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [33:0] div_q;
  logic [33:0] rem_q;
  logic [39:0] quot_q;
  logic        neg_q;

  logic        valid_q;
  logic [40:0] recip_q;
  logic        neg_out_q;
  logic        degen_q;
  logic        cull_q;

  logic        accept;
  logic        zero_area;
  logic        cull_d;
  logic [34:0] rem_shift;
  logic        qbit_d;
  logic [33:0] rem_d;

  assign accept    = valid_in && ready_out;
  assign zero_area = (area_in == 34'd0);

`ifdef AREA_RECIPROCAL_CULL_EN
  assign cull_d = negative_in && !zero_area;
`else
  assign cull_d = 1'b0;
`endif

  // One restoring-division step: the dividend 2^40 has its only set bit in the first step.
  always_comb begin
    rem_shift = {rem_q, (cnt_q == 6'd40)};
    qbit_d    = 1'b0;
    rem_d     = rem_shift[33:0];
    if (rem_shift >= {1'b0, div_q}) begin
      qbit_d = 1'b1;
      rem_d  = 34'(rem_shift - {1'b0, div_q});
    end
  end

  // Control FSM, operand latches and registered result outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      div_q     <= 34'd0;
      rem_q     <= 34'd0;
      quot_q    <= 40'd0;
      neg_q     <= 1'b0;
      valid_q   <= 1'b0;
      recip_q   <= 41'd0;
      neg_out_q <= 1'b0;
      degen_q   <= 1'b0;
      cull_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        DIVIDE: begin
          rem_q  <= rem_d;
          quot_q <= {quot_q[38:0], qbit_d};
          cnt_q  <= cnt_q - 6'd1;
          if (cnt_q == 6'd0) begin
            state_q   <= DONE;
            valid_q   <= 1'b1;
            recip_q   <= {quot_q, qbit_d};
            neg_out_q <= neg_q;
            degen_q   <= 1'b0;
            cull_q    <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE both accept; outputs of a DONE cycle change only at its closing edge.
          if (accept) begin
            neg_q  <= negative_in;
            div_q  <= area_in;
            rem_q  <= 34'd0;
            quot_q <= 40'd0;
            cnt_q  <= 6'd40;
            if (zero_area || cull_d) begin
              state_q   <= DONE;
              valid_q   <= 1'b1;
              recip_q   <= 41'd0;
              neg_out_q <= negative_in;
              degen_q   <= zero_area;
              cull_q    <= cull_d;
            end else begin
              state_q <= DIVIDE;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign ready_out      = !rst_in && (state_q != DIVIDE);
  assign valid_out      = !rst_in && valid_q;
  assign recip_out      = rst_in ? 41'd0 : recip_q;
  assign negative_out   = !rst_in && neg_out_q;
  assign degenerate_out = !rst_in && degen_q;
  assign culled_out     = !rst_in && cull_q;

endmodule

// File: tb/tb_area_reciprocal.sv
// Bench for area_reciprocal: reference model of result timing/values plus literal spot checks.
module tb_area_reciprocal;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid_in = 1'b0;
  logic        negative_in = 1'b0;
  logic [33:0] area_in = 34'd0;
  logic        ready_out;
  logic        valid_out;
  logic [40:0] recip_out;
  logic        negative_out;
  logic        degenerate_out;
  logic        culled_out;

  area_reciprocal dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .negative_in(negative_in),
    .area_in(area_in), .ready_out(ready_out), .valid_out(valid_out), .recip_out(recip_out),
    .negative_out(negative_out), .degenerate_out(degenerate_out), .culled_out(culled_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc++;

`ifdef AREA_RECIPROCAL_CULL_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif

  // Reference model: at most one transaction in flight.
  int          busy_end = -1;
  int          due = -1;
  logic [40:0] m_recip;
  logic        m_neg, m_deg, m_cull;
  int          n_acc = 0;
  int          n_out = 0;

  always @(negedge clk_in) begin
    bit exp_ready, exp_valid;
    longint unsigned q;
    if (rst_in) begin
      total++;
      if (valid_out || negative_out || degenerate_out || culled_out || recip_out != 41'd0) begin
        bad++;
        $display("FAIL reset_outs cyc=%0d got v=%b r=%h n=%b d=%b c=%b want all 0",
                 cyc, valid_out, recip_out, negative_out, degenerate_out, culled_out);
      end
      due = -1;
      busy_end = -1;
    end else begin
      exp_ready = (cyc > busy_end);
      exp_valid = (cyc == due);
      total++;
      if (ready_out !== exp_ready) begin
        bad++;
        $display("FAIL ready cyc=%0d got %b want %b", cyc, ready_out, exp_ready);
      end
      total++;
      if (valid_out !== exp_valid) begin
        bad++;
        $display("FAIL valid cyc=%0d got %b want %b", cyc, valid_out, exp_valid);
      end
      if (exp_valid && valid_out) begin
        total++;
        if (recip_out !== m_recip || negative_out !== m_neg ||
            degenerate_out !== m_deg || culled_out !== m_cull) begin
          bad++;
          $display("FAIL result cyc=%0d got r=%0d n=%b d=%b c=%b want r=%0d n=%b d=%b c=%b",
                   cyc, recip_out, negative_out, degenerate_out, culled_out,
                   m_recip, m_neg, m_deg, m_cull);
        end
      end
      if (valid_out) n_out++;
      if (valid_in && exp_ready) begin
        n_acc++;
        m_neg = negative_in;
        m_deg = (area_in == 34'd0);
        m_cull = CULL && negative_in && (area_in != 34'd0);
        if (m_deg || m_cull) begin
          m_recip = 41'd0;
          due = cyc + 1;
        end else begin
          q = (64'd1 << 40) / {30'd0, area_in};
          m_recip = q[40:0];
          due = cyc + 42;
          busy_end = cyc + 41;
        end
      end
    end
  end

  // Single transaction with literal expected result and latency.
  task automatic run_one(input logic [33:0] a, input logic neg, input logic [40:0] exp_r,
                         input int exp_lat, input logic exp_c, input string name);
    int c0;
    int lat;
    lat = -1;
    @(posedge clk_in); #1;
    valid_in = 1'b1; negative_in = neg; area_in = a;
    c0 = cyc;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (valid_out) begin
        lat = cyc - c0;
        break;
      end
    end
    total++;
    if (lat != exp_lat || recip_out !== exp_r || culled_out !== exp_c) begin
      bad++;
      $display("FAIL %s got lat=%0d r=%0d c=%b want lat=%0d r=%0d c=%b",
               name, lat, recip_out, culled_out, exp_lat, exp_r, exp_c);
    end
    repeat (2) @(posedge clk_in);
  endtask

  initial begin
    int c0;
    int seen;
    int acc0, out0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    total++;
    if (ready_out !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset got %b want 1", ready_out);
    end

    run_one(34'h10000, 1'b0, 41'h1000000, 42, 1'b0, "one");
    run_one(34'd3 << 16, 1'b0, 41'd5592405, 42, 1'b0, "three");
    run_one(34'd1, 1'b0, 41'h100_0000_0000, 42, 1'b0, "area_min");
    run_one(34'h3_ffff_ffff, 1'b0, 41'd64, 42, 1'b0, "area_max");
    run_one(34'd0, 1'b0, 41'd0, 1, 1'b0, "zero");
    run_one(34'd0, 1'b1, 41'd0, 1, 1'b0, "zero_neg");
`ifdef AREA_RECIPROCAL_CULL_EN
    run_one(34'h10000, 1'b1, 41'd0, 1, 1'b1, "cull");
`else
    run_one(34'h10000, 1'b1, 41'h1000000, 42, 1'b0, "neg_nocull");
`endif

    // Reset in the middle of a division: transaction must vanish.
    @(posedge clk_in); #1;
    valid_in = 1'b1; negative_in = 1'b0; area_in = 34'h10000;
    c0 = cyc;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    while (cyc < c0 + 20) @(posedge clk_in);
    #1 rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    total++;
    if (ready_out !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_abort got %b want 1", ready_out);
    end
    seen = 0;
    repeat (50) begin
      @(negedge clk_in);
      if (valid_out) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_no_valid got %0d strobes want 0", seen);
    end

    // Continuous valid_in with randomized operands; model checks every cycle.
    acc0 = n_acc;
    out0 = n_out;
    @(posedge clk_in); #1;
    valid_in = 1'b1;
    repeat (1500) begin
      case ($urandom_range(0, 4))
        0: area_in = 34'd0;
        1: area_in = 34'($urandom_range(1, 255));
        2: area_in = {2'($urandom), 32'($urandom)};
        default: area_in = {2'b00, 32'($urandom)} | 34'd1;
      endcase
      negative_in = 1'($urandom);
      @(posedge clk_in); #1;
    end
    valid_in = 1'b0;
    repeat (50) @(posedge clk_in);
    @(negedge clk_in);
    total++;
    if ((n_acc - acc0) != (n_out - out0) || (n_acc - acc0) < 30) begin
      bad++;
      $display("FAIL strobe_count got %0d strobes want %0d", n_out - out0, n_acc - acc0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
